led_mode_sequencer: RTL
=======================

Name: led_mode_sequencer

Overview:
Controller for the LED display interval timer (time_mode). It steps through a programmable table of up to NUM_MODES display modes, each with its own duration. For each mode it loads the duration into the timer's tm_value, gates the timer with count_en, and advances to the next mode on the timer's fc pulse. It sits between the display control logic (start/stop/hold, table writes) and the time_mode instance, and reports the current mode index to the display mux.

Parameters:
NUM_MODES, 4, number of mode slots in the duration table
IDX_W, 2, width of mode index (clog2 of NUM_MODES)
TW, 27, width of duration / tm_value
DEFAULT_DUR, 50_000_000, reset value of every duration slot

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous reset, active-low (0 = reset)
start  in  1  begin sequence at mode 0 (honoured only in IDLE)
stop  in  1  abort to IDLE from any state
hold  in  1  level; freeze timer while high in RUN
loop  in  1  1 = wrap after last mode; 0 = finish after last mode
cfg_we  in  1  duration table write strobe
cfg_addr  in  IDX_W  slot to write
cfg_data  in  TW  duration value; 0 = slot disabled
fc  in  1  interval-complete pulse from time_mode
tm_value  out  TW  interval to time_mode (registered)
count_en  out  1  timer enable to time_mode (registered)
mode_idx  out  IDX_W  current mode
busy  out  1  high in any state other than IDLE
mode_chg  out  1  one-cycle pulse in the first RUN cycle of each mode
seq_done  out  1  one-cycle pulse when sequence ends (loop=0 end, or all slots disabled)

Behaviour:
- Reset (rst=0 at clock edge): state=IDLE; tm_value=0; count_en=0; mode_idx=0; busy=0; mode_chg=0; seq_done=0; all slots=DEFAULT_DUR.
- States: IDLE, LOAD, RUN, PAUSE. Priority: reset > stop > all other inputs.
- IDLE: count_en=0. start=1 -> LOAD with mode_idx=0, skip counter cleared.
- LOAD (1 cycle, count_en=0):
  - If slot[mode_idx] != 0: tm_value<=slot[mode_idx], next state RUN.
  - If slot[mode_idx] == 0: skip. Increment skip counter and advance mode_idx by the wrap/loop rule; stay in LOAD.
  - If NUM_MODES consecutive skips occur: go to IDLE and pulse seq_done.
- RUN: count_en=1; mode_chg=1 in the first RUN cycle only.
  - fc=1: advance to LOAD, count_en=0 next cycle, skip counter cleared.
  - Next index is mode_idx+1. At NUM_MODES-1 it wraps to 0 if loop=1; if loop=0, go to IDLE with seq_done pulse and mode_idx kept.
  - hold=1 with fc=0 -> PAUSE. fc=1 and hold=1 in the same cycle: fc wins.
- PAUSE: count_en=0, tm_value held, fc ignored. hold=0 -> RUN with no mode_chg pulse.
- stop=1 in any state: IDLE next cycle; count_en=0; mode_idx unchanged; no seq_done.
- start outside IDLE is ignored.
- Latency: start sampled at edge N -> LOAD after N, RUN (count_en=1, mode_chg=1) after N+1. fc sampled at edge K -> LOAD after K, RUN after K+1. Minimum count_en low gap between modes = 1 cycle, which clears the timer's count.
- Table writes: accepted any cycle, take effect at the next LOAD of that slot. A write to the slot being read in its LOAD cycle: the old value is loaded. A running mode is not retimed by a write.
- tm_value is never driven with 0 while count_en=1.
- seq_done and mode_chg are never high in the same cycle.

Test Plan:
- Reset: rst=0 for 5 cycles with start=1 -> all outputs 0, state IDLE; after release, read back via a run that slot 0 loads 50_000_000.
- Basic sequence: slots=3,5,2,4; loop=0; start; model timer fc after tm_value enabled cycles -> mode_idx 0,1,2,3; mode_chg pulses 4 times; tm_value 3,5,2,4; count_en low exactly 1 cycle between modes; seq_done one pulse; busy falls with it.
- Skip and wrap: slots=3,0,0,4; loop=1 -> mode_idx order 0,3,0,3 with mode_chg per mode. All slots=0 with start -> seq_done after 4 LOAD cycles, count_en never high.
- Hold: slot0=10; hold=1 for 7 cycles mid-RUN -> count_en=0 for exactly those cycles, fc injected during PAUSE ignored, no mode_chg on resume. Same-cycle fc and hold -> mode advances.
- Stop and reset mid-run: stop during RUN of mode 2 -> IDLE next cycle, count_en=0, mode_idx=2, no seq_done. rst=0 during RUN -> full reset values next cycle.
- Config race: cfg_we to slot 1 with 7 during the LOAD of slot 1 (old 5) -> tm_value=5. Next pass through slot 1 -> tm_value=7.

Source files
------------

// File: rtl/led_mode_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : led_mode_sequencer_if
// Description : Control, table-write and timer handshake bundle for the LED
//               mode sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface led_mode_sequencer_if #(
    parameter int IDX_W = 2,
    parameter int TW    = 27
);
    logic             start;
    logic             stop;
    logic             hold;
    logic             loop;
    logic             cfg_we;
    logic [IDX_W-1:0] cfg_addr;
    logic [TW-1:0]    cfg_data;
    logic             fc;
    logic [TW-1:0]    tm_value;
    logic             count_en;
    logic [IDX_W-1:0] mode_idx;
    logic             busy;
    logic             mode_chg;
    logic             seq_done;

    modport master (
        output start, stop, hold, loop, cfg_we, cfg_addr, cfg_data, fc,
        input  tm_value, count_en, mode_idx, busy, mode_chg, seq_done
    );

    modport slave (
        input  start, stop, hold, loop, cfg_we, cfg_addr, cfg_data, fc,
        output tm_value, count_en, mode_idx, busy, mode_chg, seq_done
    );
endinterface
`default_nettype wire

// File: rtl/led_mode_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : led_mode_sequencer
// Description : Steps the interval timer through a programmable table of
//               display-mode durations, advancing on each fc pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module led_mode_sequencer #(
    parameter int NUM_MODES   = 4,
    parameter int IDX_W       = 2,
    parameter int TW          = 27,
    parameter int DEFAULT_DUR = 50_000_000
) (
    input  wire logic           clk,
    input  wire logic           rst,
    led_mode_sequencer_if.slave seq_if
);
    localparam logic [1:0]       c_IDLE  = 2'd0;
    localparam logic [1:0]       c_LOAD  = 2'd1;
    localparam logic [1:0]       c_RUN   = 2'd2;
    localparam logic [1:0]       c_PAUSE = 2'd3;

    localparam logic [IDX_W-1:0] c_LAST_IDX    = IDX_W'(NUM_MODES - 1);
    localparam logic [IDX_W:0]   c_SKIP_LIMIT  = (IDX_W + 1)'(NUM_MODES);
    localparam logic [TW-1:0]    c_DEFAULT_DUR = TW'(DEFAULT_DUR);

    logic [1:0]       r_state;
    logic [IDX_W-1:0] r_mode_idx;
    logic [IDX_W:0]   r_skip_cnt;
    logic [TW-1:0]    r_tm_value;
    logic             r_count_en;
    logic             r_mode_chg;
    logic             r_seq_done;
    logic [TW-1:0]    r_slots [NUM_MODES];

    logic [TW-1:0]    w_cur_dur;
    logic             w_at_last;
    logic [IDX_W-1:0] w_next_idx;
    logic [IDX_W:0]   w_skip_next;
    logic             w_cfg_addr_ok;

    assign w_cur_dur   = r_slots[r_mode_idx];
    assign w_at_last   = (r_mode_idx == c_LAST_IDX);
    assign w_next_idx  = w_at_last ? '0 : r_mode_idx + 1'b1;
    assign w_skip_next = r_skip_cnt + 1'b1;

    // Only a table that does not fill the address space needs a range guard.
    generate
        if (NUM_MODES < (1 << IDX_W)) begin : g_addr_guard
            assign w_cfg_addr_ok = (seq_if.cfg_addr < IDX_W'(NUM_MODES));
        end else begin : g_addr_full
            assign w_cfg_addr_ok = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= c_IDLE;
            r_mode_idx <= '0;
            r_skip_cnt <= '0;
            r_tm_value <= '0;
            r_count_en <= 1'b0;
            r_mode_chg <= 1'b0;
            r_seq_done <= 1'b0;
            for (int i = 0; i < NUM_MODES; i++) begin
                r_slots[i] <= c_DEFAULT_DUR;
            end
        end else begin
            r_mode_chg <= 1'b0;
            r_seq_done <= 1'b0;

            // LOAD reads the pre-write value, so a same-cycle write lands next pass.
            if (seq_if.cfg_we && w_cfg_addr_ok) begin
                r_slots[seq_if.cfg_addr] <= seq_if.cfg_data;
            end

            if (seq_if.stop) begin
                r_state    <= c_IDLE;
                r_count_en <= 1'b0;
            end else begin
                case (r_state)
                    c_IDLE: begin
                        r_count_en <= 1'b0;
                        if (seq_if.start) begin
                            r_state    <= c_LOAD;
                            r_mode_idx <= '0;
                            r_skip_cnt <= '0;
                        end
                    end

                    c_LOAD: begin
                        if (w_cur_dur != '0) begin
                            r_tm_value <= w_cur_dur;
                            r_count_en <= 1'b1;
                            r_mode_chg <= 1'b1;
                            r_state    <= c_RUN;
                        end else if ((w_skip_next == c_SKIP_LIMIT) ||
                                     (w_at_last && !seq_if.loop)) begin
                            r_state    <= c_IDLE;
                            r_seq_done <= 1'b1;
                        end else begin
                            r_skip_cnt <= w_skip_next;
                            r_mode_idx <= w_next_idx;
                        end
                    end

                    c_RUN: begin
                        if (seq_if.fc) begin
                            r_count_en <= 1'b0;
                            if (w_at_last && !seq_if.loop) begin
                                r_state    <= c_IDLE;
                                r_seq_done <= 1'b1;
                            end else begin
                                r_state    <= c_LOAD;
                                r_mode_idx <= w_next_idx;
                                r_skip_cnt <= '0;
                            end
                        end else if (seq_if.hold) begin
                            r_state    <= c_PAUSE;
                            r_count_en <= 1'b0;
                        end
                    end

                    c_PAUSE: begin
                        if (!seq_if.hold) begin
                            r_state    <= c_RUN;
                            r_count_en <= 1'b1;
                        end
                    end

                    default: begin
                        r_state    <= c_IDLE;
                        r_count_en <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign seq_if.tm_value = r_tm_value;
    assign seq_if.count_en = r_count_en;
    assign seq_if.mode_idx = r_mode_idx;
    assign seq_if.busy     = (r_state != c_IDLE);
    assign seq_if.mode_chg = r_mode_chg;
    assign seq_if.seq_done = r_seq_done;
endmodule
`default_nettype wire
